// File: rtl/gbf_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : gbf_fill_controller
// Description : Producer side of the GBF fill handshake. Watches the
//               per-buffer need_data requests of one double-buffered GBF,
//               pulls lines from a valid/ready stream into port A of buffer
//               1 or 2, flags the filled buffer ready and tracks how many
//               fills remain in the source.
// Revision    : 1.0 - initial release
// ============================================================================
module gbf_fill_controller #(
    parameter int GBF_DATA_BITWIDTH = 256,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32,
    parameter int FILL_COUNT        = 32,
    parameter int TOTAL_FILLS       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         gbf1_need_data,
    input  logic                         gbf2_need_data,
    input  logic                         s_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic                         en1a,
    output logic                         we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         buf1_ready,
    output logic                         buf2_ready,
    output logic                         data_avail,
    output logic                         busy
);

    localparam int FD_W = $clog2(TOTAL_FILLS + 1);
    // Last line index of a fill; clamped to the buffer depth so the line
    // counter can never run past the end of a buffer.
    localparam int FILL_LAST = ((FILL_COUNT > GBF_DEPTH) ? GBF_DEPTH : FILL_COUNT) - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL1 = 3'd1,
        ST_FILL2 = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [FD_W-1:0]                fills_q, fills_d;
    logic                           last2_q, last2_d;     // 1: buffer 2 was filled last
    logic                           flush2_q, flush2_d;   // buffer being flushed is buffer 2
    logic                           en1_q, en1_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   addr1_q, addr1_d;
    logic [GBF_DATA_BITWIDTH-1:0]   data1_q, data1_d;
    logic                           en2_q, en2_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   addr2_q, addr2_d;
    logic [GBF_DATA_BITWIDTH-1:0]   data2_q, data2_d;
    logic                           rdy1_q, rdy1_d;
    logic                           rdy2_q, rdy2_d;
    logic                           avail_q, avail_d;
    logic                           busy_q, busy_d;

    logic                           w_accept;
    logic                           w_go1;
    logic                           w_go2;
    logic [FD_W-1:0]                w_fills_inc;

    assign s_ready  = (state_q == ST_FILL1) || (state_q == ST_FILL2);
    assign w_accept = s_valid && s_ready;

    // With both requests pending, service the buffer not filled last.
    assign w_go1 = gbf1_need_data && (!gbf2_need_data || last2_q);
    assign w_go2 = gbf2_need_data && (!gbf1_need_data || !last2_q);

    assign w_fills_inc = fills_q + FD_W'(1);

    // State register and all registered outputs; reset aborts any fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fills_q  <= '0;
            last2_q  <= 1'b1;
            flush2_q <= 1'b0;
            en1_q    <= 1'b0;
            addr1_q  <= '0;
            data1_q  <= '0;
            en2_q    <= 1'b0;
            addr2_q  <= '0;
            data2_q  <= '0;
            rdy1_q   <= 1'b0;
            rdy2_q   <= 1'b0;
            avail_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fills_q  <= fills_d;
            last2_q  <= last2_d;
            flush2_q <= flush2_d;
            en1_q    <= en1_d;
            addr1_q  <= addr1_d;
            data1_q  <= data1_d;
            en2_q    <= en2_d;
            addr2_q  <= addr2_d;
            data2_q  <= data2_d;
            rdy1_q   <= rdy1_d;
            rdy2_q   <= rdy2_d;
            avail_q  <= avail_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: request arbitration, beat capture and fill bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fills_d  = fills_q;
        last2_d  = last2_q;
        flush2_d = flush2_q;
        en1_d    = 1'b0;
        addr1_d  = addr1_q;
        data1_d  = data1_q;
        en2_d    = 1'b0;
        addr2_d  = addr2_q;
        data2_d  = data2_q;
        rdy1_d   = rdy1_q;
        rdy2_d   = rdy2_q;
        avail_d  = avail_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (w_go1) begin
                    state_d = ST_FILL1;
                    rdy1_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (w_go2) begin
                    state_d = ST_FILL2;
                    rdy2_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_FILL1, ST_FILL2: begin
                if (w_accept) begin
                    if (state_q == ST_FILL1) begin
                        en1_d   = 1'b1;
                        addr1_d = cnt_q;
                        data1_d = s_data;
                    end else begin
                        en2_d   = 1'b1;
                        addr2_d = cnt_q;
                        data2_d = s_data;
                    end
                    if (cnt_q == GBF_ADDR_BITWIDTH'(FILL_LAST)) begin
                        cnt_d    = '0;
                        state_d  = ST_FLUSH;
                        flush2_d = (state_q == ST_FILL2);
                    end else begin
                        cnt_d = cnt_q + GBF_ADDR_BITWIDTH'(1);
                    end
                end
            end

            // The final write is on the port this cycle; publish the fill next.
            ST_FLUSH: begin
                if (flush2_q) begin
                    rdy2_d  = 1'b1;
                    last2_d = 1'b1;
                end else begin
                    rdy1_d  = 1'b1;
                    last2_d = 1'b0;
                end
                fills_d = w_fills_inc;
                busy_d  = 1'b0;
                if (w_fills_inc == FD_W'(TOTAL_FILLS)) begin
                    avail_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign en1a       = en1_q;
    assign we1a       = en1_q;
    assign addr1a     = addr1_q;
    assign w_data1a   = data1_q;
    assign en2a       = en2_q;
    assign we2a       = en2_q;
    assign addr2a     = addr2_q;
    assign w_data2a   = data2_q;
    assign buf1_ready = rdy1_q;
    assign buf2_ready = rdy2_q;
    assign data_avail = avail_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gbf_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbf_fill_controller
// Description : Directed self-checking bench for gbf_fill_controller
//               (FILL_COUNT=32, TOTAL_FILLS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbf_fill_controller;

    localparam int DW = 256;
    localparam int AW = 5;
    localparam int FC = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          gbf1_need_data;
    logic          gbf2_need_data;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail, busy;

    int n_chk  = 0;
    int n_fail = 0;

    gbf_fill_controller #(
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (32),
        .FILL_COUNT        (FC),
        .TOTAL_FILLS       (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .gbf1_need_data (gbf1_need_data),
        .gbf2_need_data (gbf2_need_data),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .en1a           (en1a),
        .we1a           (we1a),
        .addr1a         (addr1a),
        .w_data1a       (w_data1a),
        .en2a           (en2a),
        .we2a           (we2a),
        .addr2a         (addr2a),
        .w_data2a       (w_data2a),
        .buf1_ready     (buf1_ready),
        .buf2_ready     (buf2_ready),
        .data_avail     (data_avail),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkline(input int v);
        logic [31:0] w;
        w = 32'(v);
        return {8{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check every output against its reset value, release.
    task automatic do_reset();
        reset = 1'b1;
        gbf1_need_data = 1'b0;
        gbf2_need_data = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_en1a", {en1a, we1a}, 0);
        chk("rst_addr1a", addr1a, 0);
        chk("rst_w_data1a", w_data1a, 0);
        chk("rst_en2a", {en2a, we2a}, 0);
        chk("rst_addr2a", addr2a, 0);
        chk("rst_w_data2a", w_data2a, 0);
        chk("rst_buf_ready", {buf1_ready, buf2_ready}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_avail", data_avail, 1);
        step();
        step();
        reset = 1'b0;
    endtask

    // Run one complete fill of buffer b, checking every cycle from the first
    // FILL cycle up to and including the cycle buf_ready rises.
    task automatic fill(input int b, input int base, input bit gap, input int drop_beat,
                        input bit last, input int exp_cycles);
        int  cyc, beat, last_acc, w, pidx;
        bit  pend, done;
        logic en_x, we_x, en_o, we_o, rdy;
        logic [AW-1:0] addr_x;
        logic [DW-1:0] data_x;
        w = 0;
        while (!s_ready && w < 5) begin
            step();
            w++;
        end
        chk("fill_start", s_ready, 1);
        chk("ready_cleared", (b == 1) ? buf1_ready : buf2_ready, 0);
        chk("busy_start", busy, 1);
        cyc = 1; beat = 0; last_acc = 0; pend = 0; pidx = 0; done = 0;
        while (!done && cyc <= 200) begin
            en_x   = (b == 1) ? en1a : en2a;
            we_x   = (b == 1) ? we1a : we2a;
            addr_x = (b == 1) ? addr1a : addr2a;
            data_x = (b == 1) ? w_data1a : w_data2a;
            en_o   = (b == 1) ? en2a : en1a;
            we_o   = (b == 1) ? we2a : we1a;
            rdy    = (b == 1) ? buf1_ready : buf2_ready;
            if (pend) begin
                chk("wr_en_we", {en_x, we_x}, 2'b11);
                chk("wr_addr", addr_x, pidx);
                chk("wr_data", data_x, mkline(base + pidx));
            end else begin
                chk("no_wr", {en_x, we_x}, 0);
            end
            chk("other_port_idle", {en_o, we_o}, 0);
            if (rdy) begin
                done = 1;
            end else begin
                chk("data_avail_mid", data_avail, 1);
                chk("busy_mid", busy, 1);
                pend = 0;
                if (s_ready) begin
                    s_valid = gap ? (cyc % 2 == 1) : 1'b1;
                    s_data  = mkline(base + beat);
                    if (s_valid) begin
                        pend = 1;
                        pidx = beat;
                        beat++;
                        last_acc = cyc;
                        if (beat == drop_beat) begin
                            if (b == 1) gbf1_need_data = 1'b0;
                            else        gbf2_need_data = 1'b0;
                        end
                    end
                end else begin
                    s_valid = 1'b0;
                end
                step();
                cyc++;
            end
        end
        s_valid = 1'b0;
        chk("ready_seen", done, 1);
        chk("beats", beat, FC);
        chk("fill_cycles", cyc, exp_cycles);
        chk("ready_latency", cyc - last_acc, 2);
        chk("data_avail_end", data_avail, last ? 0 : 1);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        gbf1_need_data = 1'b0;
        gbf2_need_data = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        // Single back-to-back fill of buffer 1 with lines 0..31.
        do_reset();
        gbf1_need_data = 1'b1;
        fill(1, 0, 1'b0, -1, 1'b0, FC + 2);
        gbf1_need_data = 1'b0;
        chk("a_buf2_idle", buf2_ready, 0);

        // Both requests held: 1, 2, 1, 2 ping-pong until the source runs dry.
        do_reset();
        gbf1_need_data = 1'b1;
        gbf2_need_data = 1'b1;
        fill(1, 1000, 1'b0, -1, 1'b0, FC + 2);
        fill(2, 2000, 1'b0, -1, 1'b0, FC + 2);
        chk("b_buf1_kept", buf1_ready, 1);
        fill(1, 3000, 1'b0, -1, 1'b0, FC + 2);
        chk("b_buf2_kept", buf2_ready, 1);
        fill(2, 4000, 1'b0, -1, 1'b1, FC + 2);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("done_s_ready", s_ready, 0);
            chk("done_no_wr", {en1a, we1a, en2a, we2a}, 0);
            chk("done_ready_flags", {buf1_ready, buf2_ready}, 2'b11);
            chk("done_data_avail", data_avail, 0);
            chk("done_busy", busy, 0);
        end

        // Alternating s_valid, with the request dropped after beat 5.
        do_reset();
        gbf1_need_data = 1'b1;
        fill(1, 5000, 1'b1, 5, 1'b0, 2 * FC + 1);
        step();
        chk("c_no_refill", s_ready, 0);

        // Reset after 10 beats of a buffer 2 fill, then a fresh buffer 1 fill.
        do_reset();
        gbf2_need_data = 1'b1;
        step();
        chk("d_fill2_start", s_ready, 1);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = mkline(6000 + i);
            step();
        end
        chk("d_partial_addr", addr2a, 9);
        do_reset();
        chk("d_buf2_not_ready", buf2_ready, 0);
        gbf1_need_data = 1'b1;
        fill(1, 7000, 1'b0, -1, 1'b0, FC + 2);
        chk("d_buf2_still_0", buf2_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
